if_fetch: RTL

Instruction fetch stage that feeds the instruction decoder. Owns the program counter, issues in-order read requests to instruction memory with a credit-limited number of outstanding requests, and buffers returned 16-bit instructions in a small queue. Presents `if_pc`/`if_inst` with a valid flag to decode, honours decode stalls, and discards stale fetches on a redirect (branch/jump) from execute.

---
 rtl/if_fetch.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/if_fetch.sv
// if_fetch: instruction fetch stage.
// Owns the program counter, issues in-order instruction memory reads limited
// by a credit of DEPTH (in-flight plus queued), buffers returned instructions
// in a DEPTH-entry queue and presents the queue head to decode from registers.
// Redirects empty the queue and mark every live in-flight fetch for discard.
// Optional feature macro: IF_PERF_CNT_EN (adds stall/bubble perf counters).

module if_fetch #(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 16,
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [INST_W-1:0] mem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              id_stall,
    output logic              if_valid,
    output logic [ADDR_W-1:0] if_pc,
    output logic [INST_W-1:0] if_inst
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_bubble_cnt
`endif
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] r_resp_pc;
    logic [CW-1:0]     r_outstanding;
    logic [CW-1:0]     r_drop_cnt;
    logic [CW-1:0]     r_count;
    logic [PW-1:0]     r_rd_ptr;
    logic [PW-1:0]     r_wr_ptr;
    logic [ADDR_W-1:0] r_q_pc   [DEPTH];
    logic [INST_W-1:0] r_q_inst [DEPTH];
    logic              r_if_valid;
    logic [ADDR_W-1:0] r_if_pc;
    logic [INST_W-1:0] r_if_inst;

    logic              w_credit_ok;
    logic              w_grant;
    logic              w_push;
    logic              w_pop;
    logic [CW-1:0]     w_live;
    logic [CW-1:0]     w_outstanding_nxt;
    logic [CW-1:0]     w_drop_nxt;
    logic [CW-1:0]     w_count_nxt;
    logic [PW-1:0]     w_rd_ptr_nxt;
    logic [PW-1:0]     w_wr_ptr_nxt;
    logic              w_head_new;
    logic              w_if_valid_nxt;
    logic [ADDR_W-1:0] w_if_pc_nxt;
    logic [INST_W-1:0] w_if_inst_nxt;

    // Credit check counts both in-flight fetches and queued instructions.
    assign w_credit_ok = ({1'b0, r_outstanding} + {1'b0, r_count}) < (CW+1)'(DEPTH);
    // Request is held low during reset and in a redirect cycle.
    assign mem_req     = rst && !redirect_valid && w_credit_ok;
    assign mem_addr    = r_fetch_pc;
    assign w_grant     = mem_req && mem_gnt;
    assign w_push      = mem_rvalid && !redirect_valid && (r_drop_cnt == {CW{1'b0}});
    assign w_pop       = r_if_valid && !id_stall && !redirect_valid;
    assign w_live      = r_outstanding - r_drop_cnt;

    assign if_valid = r_if_valid;
    assign if_pc    = r_if_pc;
    assign if_inst  = r_if_inst;

    // Next-state for counters, pointers and the registered head presentation.
    always_comb begin
        w_outstanding_nxt = r_outstanding + CW'(w_grant) - CW'(mem_rvalid);
        w_wr_ptr_nxt      = r_wr_ptr + PW'(w_push);
        w_drop_nxt        = r_drop_cnt;
        w_count_nxt       = r_count;
        w_rd_ptr_nxt      = r_rd_ptr;
        if (redirect_valid) begin
            // Every live fetch becomes stale; one arriving now is dropped directly.
            w_drop_nxt   = r_drop_cnt + w_live - CW'(mem_rvalid);
            w_count_nxt  = {CW{1'b0}};
            w_rd_ptr_nxt = r_wr_ptr;
        end else begin
            if (mem_rvalid && (r_drop_cnt != {CW{1'b0}})) begin
                w_drop_nxt = r_drop_cnt - {{(CW-1){1'b0}}, 1'b1};
            end else begin
                w_drop_nxt = r_drop_cnt;
            end
            w_count_nxt  = r_count + CW'(w_push) - CW'(w_pop);
            w_rd_ptr_nxt = r_rd_ptr + PW'(w_pop);
        end

        // The new response becomes the head when the queue is empty after the pop.
        w_head_new = w_push && ((r_count - CW'(w_pop)) == {CW{1'b0}});
        if (w_count_nxt == {CW{1'b0}}) begin
            w_if_valid_nxt = 1'b0;
            w_if_pc_nxt    = {ADDR_W{1'b0}};
            w_if_inst_nxt  = {INST_W{1'b0}};
        end else if (w_head_new) begin
            w_if_valid_nxt = 1'b1;
            w_if_pc_nxt    = r_resp_pc;
            w_if_inst_nxt  = mem_rdata;
        end else begin
            w_if_valid_nxt = 1'b1;
            w_if_pc_nxt    = r_q_pc[w_rd_ptr_nxt];
            w_if_inst_nxt  = r_q_inst[w_rd_ptr_nxt];
        end
    end

    // Fetch state, queue storage and registered decode outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= {CW{1'b0}};
            r_drop_cnt    <= {CW{1'b0}};
            r_count       <= {CW{1'b0}};
            r_rd_ptr      <= {PW{1'b0}};
            r_wr_ptr      <= {PW{1'b0}};
            r_if_valid    <= 1'b0;
            r_if_pc       <= {ADDR_W{1'b0}};
            r_if_inst     <= {INST_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                r_q_pc[i]   <= {ADDR_W{1'b0}};
                r_q_inst[i] <= {INST_W{1'b0}};
            end
        end else begin
            if (redirect_valid) begin
                r_fetch_pc <= redirect_pc;
                r_resp_pc  <= redirect_pc;
            end else begin
                if (w_grant) begin
                    r_fetch_pc <= r_fetch_pc + {{(ADDR_W-1){1'b0}}, 1'b1};
                end
                if (w_push) begin
                    r_resp_pc <= r_resp_pc + {{(ADDR_W-1){1'b0}}, 1'b1};
                end
            end
            if (w_push) begin
                r_q_pc[r_wr_ptr]   <= r_resp_pc;
                r_q_inst[r_wr_ptr] <= mem_rdata;
            end
            r_outstanding <= w_outstanding_nxt;
            r_drop_cnt    <= w_drop_nxt;
            r_count       <= w_count_nxt;
            r_rd_ptr      <= w_rd_ptr_nxt;
            r_wr_ptr      <= w_wr_ptr_nxt;
            r_if_valid    <= w_if_valid_nxt;
            r_if_pc       <= w_if_pc_nxt;
            r_if_inst     <= w_if_inst_nxt;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_bubble;

    assign perf_stall_cnt  = r_perf_stall;
    assign perf_bubble_cnt = r_perf_bubble;

    // Saturating counters of stalled-valid cycles and empty-output cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perf_stall  <= 32'd0;
            r_perf_bubble <= 32'd0;
        end else begin
            if (r_if_valid && id_stall && (r_perf_stall != 32'hFFFF_FFFF)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
            if (!r_if_valid && (r_perf_bubble != 32'hFFFF_FFFF)) begin
                r_perf_bubble <= r_perf_bubble + 32'd1;
            end
        end
    end
`endif

    if_fetch_chk #(.CW(CW), .DEPTH(DEPTH)) u_chk (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .count (r_count)
    );

endmodule

// Checker: a push into a full queue without a simultaneous pop breaks the credit rule.
module if_fetch_chk #(
    parameter int CW    = 2,
    parameter int DEPTH = 2
) (
    input logic          clk,
    input logic          rst,
    input logic          push,
    input logic          pop,
    input logic [CW-1:0] count
);
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(push && !pop && (count == CW'(DEPTH))))
        else $error("if_fetch queue overflow");
endmodule
